// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param
//   Purpose     : iterative shift-add multiplier (signed or unsigned per operation)
//                 with a Start/Busy/Done handshake and a zero flag. Out feeds the
//                 High/Low result registers as {High, Low}.
//   Latency     : Start sampled at edge k -> Done=1 and Out valid after edge k+WIDTH+1.
//   Backpressure: none; Start is only honoured in IDLE or DONE and is dropped
//                 while an operation is in flight.
// Ports
//   CLK      in   1        clock, rising edge
//   Clear    in   1        synchronous active-high reset; wins over Start, aborts an operation
//   Start    in   1        request, sampled in IDLE/DONE only
//   Signed   in   1        1 = two's-complement operands, captured with Start
//   A, B     in   WIDTH    multiplicand / multiplier, captured with Start
//   Busy     out  1        operation in progress (BUSY and FIX states)
//   Done     out  1        level, Out valid and held
//   Out      out  2*WIDTH  product
//   ZeroFlag out  1        Done & (Out == 0)
// WIDTH is legal over 4..64.

module seq_multiplier_param #(
  parameter int WIDTH = 32
) (
  input  logic               CLK,
  input  logic               Clear,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Out,
  output logic               ZeroFlag
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;   // |A|
  logic [WIDTH-1:0]   mplier;  // |B|, consumed LSB first
  logic [2*WIDTH-1:0] acc;     // partial product, full product after WIDTH steps
  logic [CW-1:0]      count;
  logic               neg;     // product sign, applied once in FIX

  // Datapath helpers
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    a_mag  = A;
    b_mag  = B;
    sum    = '0;
    result = acc;

    // Magnitudes are only taken in signed mode. The most negative value maps
    // onto 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    if (Signed && A[WIDTH-1]) a_mag = -A;
    if (Signed && B[WIDTH-1]) b_mag = -B;

    // (WIDTH+1)-bit add into the upper half; the carry becomes the new MSB
    // after the right shift so no product bit is ever lost.
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

    if (neg) result = -acc;
  end

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Out      <= '0;
      ZeroFlag <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Out keeps the previous result until FIX overwrites it.
          if (Start) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            neg      <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc      <= '0;
            count    <= '0;
            state    <= BUSY;
            Busy     <= 1'b1;
            Done     <= 1'b0;
            ZeroFlag <= 1'b0;
          end
        end

        BUSY: begin
          // Shift {carry, acc, mplier} right by one. The bits leaving acc
          // refill mplier from the top; they are never examined again.
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= {acc[0], mplier[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          Out      <= result;
          ZeroFlag <= (result == '0);
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state    <= DONE;
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// tb_seq_multiplier_param
//   Directed bench for seq_multiplier_param at WIDTH=32 and WIDTH=8.
//   Expected values are hand-computed constants.

module tb_seq_multiplier_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, st, sg;
  logic [31:0] a, b;
  logic        busy, done, zf;
  logic [63:0] out;

  logic        st8, sg8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zf8;
  logic [15:0] out8;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int low;

  seq_multiplier_param #(.WIDTH(32)) dut32 (
    .CLK(clk), .Clear(clr), .Start(st), .Signed(sg), .A(a), .B(b),
    .Busy(busy), .Done(done), .Out(out), .ZeroFlag(zf)
  );

  seq_multiplier_param #(.WIDTH(8)) dut8 (
    .CLK(clk), .Clear(clr), .Start(st8), .Signed(sg8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Out(out8), .ZeroFlag(zf8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse Start for one edge, then count edges until Done (bounded).
  task automatic run32(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                       output int latency);
    sg = s; a = aa; b = bb; st = 1'b1;
    tick;
    st = 1'b0;
    latency = 0;
    while (!done && latency < 200) begin
      tick;
      latency++;
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                      output int latency);
    sg8 = s; a8 = aa; b8 = bb; st8 = 1'b1;
    tick;
    st8 = 1'b0;
    latency = 0;
    while (!done8 && latency < 200) begin
      tick;
      latency++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; st = 1'b0; sg = 1'b0; a = '0; b = '0;
    st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    tick; tick;
    clr = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out",  out,       64'd0);
    chk("rst_zf",   64'(zf),   64'd0);

    // 1. Unsigned 0x7F * 0x70, latency and hold in DONE
    run32(1'b0, 32'h7F, 32'h70, lat);
    chk("t1_lat",  64'(lat),  64'd33);
    chk("t1_out",  out,       64'h0000_0000_0000_3790);
    chk("t1_zf",   64'(zf),   64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    tick; tick; tick;
    chk("t1_hold_out",  out,       64'h0000_0000_0000_3790);
    chk("t1_hold_done", 64'(done), 64'd1);

    // 2. All-ones operands, both modes
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("t2_uns", out, 64'hFFFF_FFFE_0000_0001);
    run32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("t2_sgn", out, 64'h0000_0000_0000_0001);

    // 3. Signed sign handling and signed minimum
    run32(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    chk("t3_neg1", out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_neg1_zf", 64'(zf), 64'd0);
    run32(1'b1, 32'h8000_0000, 32'h8000_0000, lat);
    chk("t3_min", out, 64'h4000_0000_0000_0000);

    // 4. Zero result, then back-to-back Start while in DONE
    run32(1'b0, 32'h0, 32'h1234_5678, lat);
    chk("t4_zero_out", out,      64'd0);
    chk("t4_zero_zf",  64'(zf),  64'd1);
    sg = 1'b0; a = 32'd2; b = 32'd3; st = 1'b1;
    tick;
    st = 1'b0;
    chk("t4_done_drop", 64'(done), 64'd0);
    chk("t4_zf_drop",   64'(zf),   64'd0);
    low = 0;
    while (!done && low < 200) begin
      low++;
      tick;
    end
    chk("t4_low_cycles", 64'(low), 64'd33);
    chk("t4_out", out, 64'd6);

    // 5a. Start pulses with other operands while BUSY are ignored
    sg = 1'b0; a = 32'h1234; b = 32'h10; st = 1'b1;
    tick;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      if (done) break;
      if (i == 3 || i == 7 || i == 20) begin
        st = 1'b1; sg = 1'b1; a = 32'hFFFF_FFFF; b = 32'h8000_0000;
      end else begin
        st = 1'b0;
      end
      tick;
      lat++;
    end
    st = 1'b0;
    chk("t5_ign_lat", 64'(lat), 64'd33);
    chk("t5_ign_out", out,      64'h0000_0000_0001_2340);

    // 5b. Clear at the 10th BUSY edge aborts with no partial result
    sg = 1'b0; a = 32'd5; b = 32'd7; st = 1'b1;
    tick;
    st = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    chk("t5_pre_busy", 64'(busy), 64'd1);
    chk("t5_pre_out",  out,       64'h0000_0000_0001_2340);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("t5_clr_busy", 64'(busy), 64'd0);
    chk("t5_clr_done", 64'(done), 64'd0);
    chk("t5_clr_out",  out,       64'd0);
    chk("t5_clr_zf",   64'(zf),   64'd0);
    for (int i = 0; i < 40; i++) tick;
    chk("t5_after_out",  out,       64'd0);
    chk("t5_after_done", 64'(done), 64'd0);

    // 6. WIDTH=8, minimum operand in both modes
    run8(1'b1, 8'h80, 8'h80, lat);
    chk("t6_sgn_out", 64'(out8), 64'h4000);
    chk("t6_sgn_lat", 64'(lat),  64'd9);
    run8(1'b0, 8'h80, 8'h80, lat);
    chk("t6_uns_out", 64'(out8), 64'h4000);
    chk("t6_uns_lat", 64'(lat),  64'd9);
    run8(1'b1, 8'hFD, 8'h05, lat);
    chk("t6_neg_out", 64'(out8), 64'hFFF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
